booth_radix4_mult: RTL and testbench
====================================

# booth_radix4_mult

Parametrised, sequential radix-4 Booth multiplier with a start/busy/done handshake and selectable signed/unsigned operation. It succeeds the fixed 16-bit radix-2 Booth datapath/controlpath pair. It takes both operands in one cycle rather than over a shared `data_in` bus, and it retires two multiplier bits per clock. It sits as a multi-cycle arithmetic unit behind any controller that issues one multiply at a time.

## Interface
- `WIDTH`, 16, operand width in bits; must be even and at least 4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE or DONE.
- `signed_mode` in 1: 1 means operands are two's complement, 0 means unsigned; latched on the accepted `start`.
- `multiplicand` in WIDTH: the multiplicand M; latched on the accepted `start`.
- `multiplier` in WIDTH: the multiplier Q; latched on the accepted `start`.
- `busy` out 1: high while iterating (CALC).
- `done` out 1: one-cycle pulse when `product` is updated.
- `product` out 2*WIDTH: exact product, held until the next result.

## Operation
- Extended width: EW = WIDTH+2. On accept, both operands are extended to EW bits, sign-extended when `signed_mode`=1 and zero-extended otherwise.
- Iteration count: N = EW/2 = WIDTH/2+1, the same in both modes, so latency is fixed.
- Registers:
  - accumulator A, EW+2 bits, cleared on accept;
  - Q register, EW bits, loaded with the extended multiplier;
  - q_m1, 1 bit, cleared on accept;
  - M register, EW+2 bits, sign-extended from the extended multiplicand;
  - count, ceil(log2(N+1)) bits, loaded with N.
- One step per CALC cycle:
  - Recode {Q[1:0], q_m1}: 000 or 111 → +0; 001 or 010 → +M; 011 → +2M; 100 → −2M; 101 or 110 → −M.
  - Add the selected term to A, modulo 2^(EW+2).
  - Arithmetic-shift {A, Q, q_m1} right by 2, replicating the A MSB.
  - Decrement count.
- Result: after N steps, `product` is loaded with {A,Q}[2*WIDTH-1:0]. It equals the exact signed product when `signed_mode`=1 and the exact unsigned product otherwise.
- FSM states IDLE, CALC and DONE:
  - IDLE: when `start`=1, latch operands and mode, initialise registers, go to CALC. Otherwise stay.
  - CALC: perform one step. When the step with count=1 completes, load `product` and go to DONE. `start` is ignored.
  - DONE: `done`=1. When `start`=1, accept new operands and go to CALC (back-to-back). Otherwise go to IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0.
- `rst` has priority over everything. Asserting it mid-CALC aborts the operation, clears `product` to 0, and suppresses `done`.
- Let `start` be accepted at rising edge t0:
  - `busy`=1 in the N cycles after edges t0 … t0+N−1.
  - `product` is updated and `done`=1 in the cycle after edge t0+N.
- Latency from accept to `done` is N+1 edges = WIDTH/2+1 cycles of `busy` plus the DONE cycle. For WIDTH=16, N=9.
- Throughput: with `start` held high, one result every N+1 cycles. `done` stays a single-cycle pulse per result.
- Changes to operand or mode inputs after accept have no effect on the running operation.

## Structure
- Shared package `booth_pkg`:
  - state enum {IDLE, CALC, DONE};
  - recode-op enum {ZERO, ADD_M, ADD_2M, SUB_M, SUB_2M};
  - helper function computing N from WIDTH.
- One sub-module, `booth_r4_recoder`, is combinational:
  - inputs: 3-bit window and M (EW+2 bits);
  - output: the EW+2-bit addend, with subtraction as the inverted term plus a carry-in of 1.
- FSM, counter and shift datapath live in the top module.

## Test plan
- WIDTH=16, signed: 45 × −78 (0x002D × 0xFFB2) → `product`=0xFFFFF24A (−3510), with `done` exactly 10 cycles after the accepting edge.
- Unsigned corner: 0xFFFF × 0xFFFF → 0xFFFE0001. Signed corner: 0x8000 × 0x8000 → 0x40000000.
- Signed 0x8000 × 0x7FFF → 0xC0008000. The same operands unsigned → 0x3FFF8000.
- `start` pulsed with new operands during CALC → ignored. The first result is unchanged and no extra `done` occurs.
- `start` held high across DONE → second operation accepted in the DONE cycle. Results arrive 10 cycles apart, with one `done` pulse each.
- `rst` asserted at cycle 4 of CALC → next cycle shows IDLE, `busy`=0, `product`=0, and no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    ADD_M,
    ADD_2M,
    SUB_M,
    SUB_2M
  } op_e;

  // Two bits retired per step over the (WIDTH+2)-bit extended multiplier.
  function automatic int unsigned booth_iters(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to an addend.
// Subtraction is returned as the inverted term plus cin_o=1.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int unsigned AW = 20
) (
  input  logic [2:0]    win_i,
  input  logic [AW-1:0] m_i,
  output logic [AW-1:0] addend_o,
  output logic          cin_o
);

  op_e           op;
  logic [AW-1:0] m2;

  assign m2 = {m_i[AW-2:0], 1'b0};

  always_comb begin
    op = ZERO;
    case (win_i)
      3'b001, 3'b010: op = ADD_M;
      3'b011:         op = ADD_2M;
      3'b100:         op = SUB_2M;
      3'b101, 3'b110: op = SUB_M;
      default:        op = ZERO;
    endcase
  end

  always_comb begin
    addend_o = '0;
    cin_o    = 1'b0;
    case (op)
      ADD_M:   addend_o = m_i;
      ADD_2M:  addend_o = m2;
      SUB_M: begin
        addend_o = ~m_i;
        cin_o    = 1'b1;
      end
      SUB_2M: begin
        addend_o = ~m2;
        cin_o    = 1'b1;
      end
      default: addend_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, fixed latency.
// FSM, counter and shift datapath; recoding lives in booth_r4_recoder.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned AW = EW + 2;
  localparam int unsigned N  = booth_iters(WIDTH);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * WIDTH;

  state_e            state_q;
  logic [AW-1:0]     a_q;
  logic [EW-1:0]     q_q;
  logic              qm1_q;
  logic [AW-1:0]     m_q;
  logic [CW-1:0]     count_q;
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     product_q;

  logic [EW-1:0]     mcand_ext;
  logic [EW-1:0]     mplier_ext;
  logic [AW-1:0]     addend;
  logic              cin;
  logic [AW-1:0]     sum;
  logic [AW-1:0]     a_d;
  logic [EW-1:0]     q_d;
  logic              qm1_d;
  logic [PW-1:0]     product_d;

  always_comb begin
    mcand_ext  = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};
    mplier_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};
  end

  booth_r4_recoder #(
    .AW(AW)
  ) u_recoder (
    .win_i   ({q_q[1:0], qm1_q}),
    .m_i     (m_q),
    .addend_o(addend),
    .cin_o   (cin)
  );

  // Add, then arithmetic shift of {A, Q, q_m1} right by two.
  always_comb begin
    sum       = a_q + addend + AW'(cin);
    a_d       = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_d       = {sum[1:0], q_q[EW-1:2]};
    qm1_d     = q_q[1];
    product_d = {a_d[PW-EW-1:0], q_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= '0;
            q_q     <= mplier_ext;
            qm1_q   <= 1'b0;
            m_q     <= {{2{mcand_ext[EW-1]}}, mcand_ext};
            count_q <= CW'(N);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q     <= a_d;
          q_q     <= q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed bench for booth_radix4_mult (WIDTH=16) with an expected-result queue.
module tb_booth_radix4_mult;

  localparam int unsigned W = 16;
  localparam int          N = W / 2 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  booth_radix4_mult #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic sm, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = sm ? {{16{a[15]}}, a} : {16'h0000, a};
    y = sm ? {{16{b[15]}}, b} : {16'h0000, b};
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, pushes its expected product, returns #1 after the accepting edge.
  task automatic issue(input logic sm, input logic [15:0] a, input logic [15:0] b);
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(model(sm, a, b));
    tick();
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_edges);
    int          edges;
    logic [31:0] e;
    edges = 0;
    e     = 'x;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_product"}, 64'(product), 64'(e));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic run_one(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b);
    issue(sm, a, b);
    wait_done(tag, N);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int extra;

    rst          = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    rst = 1'b0;
    tick();

    run_one("s_45x-78", 1'b1, 16'h002D, 16'hFFB2);
    check("s_45x-78_const", 64'(product), 64'h0000_0000_FFFF_F24A);
    run_one("u_ffff2", 1'b0, 16'hFFFF, 16'hFFFF);
    check("u_ffff2_const", 64'(product), 64'h0000_0000_FFFE_0001);
    run_one("s_8000x8000", 1'b1, 16'h8000, 16'h8000);
    check("s_8000x8000_const", 64'(product), 64'h0000_0000_4000_0000);
    run_one("s_8000x7fff", 1'b1, 16'h8000, 16'h7FFF);
    check("s_8000x7fff_const", 64'(product), 64'h0000_0000_C000_8000);
    run_one("u_8000x7fff", 1'b0, 16'h8000, 16'h7FFF);
    check("u_8000x7fff_const", 64'(product), 64'h0000_0000_3FFF_8000);
    run_one("s_m1xm1", 1'b1, 16'hFFFF, 16'hFFFF);
    run_one("u_1234x5678", 1'b0, 16'h1234, 16'h5678);
    run_one("s_0xabcd", 1'b1, 16'h0000, 16'hABCD);
    run_one("u_1xffff", 1'b0, 16'h0001, 16'hFFFF);

    // start pulsed mid-CALC with new operands must be ignored
    issue(1'b1, 16'h0123, 16'hFF56);
    repeat (3) tick();
    signed_mode  = 1'b0;
    multiplicand = 16'hFFFF;
    multiplier   = 16'hFFFF;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy_held", 64'(busy), 64'd1);
    wait_done("ign", N - 4);
    extra = 0;
    repeat (15) begin
      tick();
      if (done) extra++;
    end
    check("ign_extra_done", 64'(extra), 64'd0);
    check("ign_product_held", 64'(product), 64'(model(1'b1, 16'h0123, 16'hFF56)));
    check("ign_idle_busy", 64'(busy), 64'd0);

    // start held high across DONE: back-to-back, operands changed after accept
    signed_mode  = 1'b1;
    multiplicand = 16'h8000;
    multiplier   = 16'h7FFF;
    start        = 1'b1;
    exp_q.push_back(model(1'b1, 16'h8000, 16'h7FFF));
    tick();
    check("b2b_busy1", 64'(busy), 64'd1);
    signed_mode  = 1'b0;
    multiplicand = 16'hBEEF;
    multiplier   = 16'h1357;
    exp_q.push_back(model(1'b0, 16'hBEEF, 16'h1357));
    wait_done("b2b1", N);
    tick();
    start = 1'b0;
    check("b2b_done_pulse1", 64'(done), 64'd0);
    check("b2b_busy2", 64'(busy), 64'd1);
    wait_done("b2b2", N);
    tick();
    check("b2b_done_pulse2", 64'(done), 64'd0);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset during CALC aborts the operation
    issue(1'b1, 16'h1111, 16'h2222);
    void'(exp_q.pop_back());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      tick();
      if (done || busy) extra++;
    end
    check("abort_quiet", 64'(extra), 64'd0);
    run_one("after_abort", 1'b1, 16'h7FFF, 16'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
